// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronizes and de-glitches encoder phases A/B, decodes
// Gray-code transitions into a one-cycle step pulse with direction, and keeps
// a WIDTH-bit position register plus a sticky illegal-transition flag.
//
// Optional feature macro: QDEC_INDEX_EN (adds z_in index input; a synchronized
// rising edge on z_in reloads position from init_value).
//
// Ports:
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   a_in, b_in  asynchronous encoder phases
//   enable      1 = emit steps and update position
//   load        synchronous load of init_value into position
//   init_value  position load value
//   err_clr     clears the sticky error flag
//   z_in        (QDEC_INDEX_EN only) asynchronous index pulse
//   step        one-cycle pulse per valid transition
//   count_up    direction of the last valid transition (1 = forward)
//   position    decoded position, modulo 2^WIDTH
//   error       sticky illegal-transition flag
module quad_decoder #(
  parameter int unsigned WIDTH       = 3,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] init_value,
  input  logic             err_clr,
`ifdef QDEC_INDEX_EN
  input  logic             z_in,
`endif
  output logic             step,
  output logic             count_up,
  output logic [WIDTH-1:0] position,
  output logic             error
);

  // Cycles after reset before the filter history holds only post-reset samples.
  localparam int unsigned PRIME_CYC = SYNC_STAGES + FILTER_LEN;
  localparam int unsigned CNT_W     = $clog2(PRIME_CYC + 1);

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_TRACK = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] a_sync_q;
  logic [SYNC_STAGES-1:0] b_sync_q;
  logic [1:0]             hist_q [FILTER_LEN];
  logic [1:0]             filt_q, filt_d;
  logic [CNT_W-1:0]       prime_cnt_q, prime_cnt_d;
  logic                   step_q, step_d;
  logic                   count_up_q, count_up_d;
  logic [WIDTH-1:0]       position_q, position_d;
  logic                   error_q, error_d;

  logic [1:0]             cand_c;
  logic                   stable_c;
  logic                   primed_c;
  logic [1:0]             dir_c;
  logic                   load_any_c;

  // Gray-code position of an {A,B} state: 00->0, 01->1, 11->2, 10->3.
  function automatic logic [1:0] gray_idx(input logic [1:0] ab);
    logic [1:0] idx;
    case (ab)
      2'b00:   idx = 2'd0;
      2'b01:   idx = 2'd1;
      2'b11:   idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  // Phase synchronizers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_sync_q <= '0;
      b_sync_q <= '0;
    end else begin
      a_sync_q <= {a_sync_q[SYNC_STAGES-2:0], a_in};
      b_sync_q <= {b_sync_q[SYNC_STAGES-2:0], b_in};
    end
  end

  // Filter history of synchronized {A,B}; entry 0 is the newest.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(FILTER_LEN); i++) hist_q[i] <= 2'b00;
    end else begin
      hist_q[0] <= {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};
      for (int i = 1; i < int'(FILTER_LEN); i++) hist_q[i] <= hist_q[i-1];
    end
  end

  // History agreement check.
  always_comb begin
    cand_c   = hist_q[0];
    stable_c = 1'b1;
    for (int i = 1; i < int'(FILTER_LEN); i++) begin
      if (hist_q[i] != hist_q[0]) stable_c = 1'b0;
    end
  end

  assign primed_c = (prime_cnt_q == CNT_W'(PRIME_CYC));
  // 1 = forward, 3 = reverse, 2 = both bits changed.
  assign dir_c    = gray_idx(cand_c) - gray_idx(filt_q);

`ifdef QDEC_INDEX_EN
  logic [SYNC_STAGES-1:0] z_sync_q;
  logic                   z_prev_q;

  // Index synchronizer and rising-edge detect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      z_sync_q <= '0;
      z_prev_q <= 1'b0;
    end else begin
      z_sync_q <= {z_sync_q[SYNC_STAGES-2:0], z_in};
      z_prev_q <= z_sync_q[SYNC_STAGES-1];
    end
  end

  assign load_any_c = load | (z_sync_q[SYNC_STAGES-1] & ~z_prev_q);
`else
  assign load_any_c = load;
`endif

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_INIT;
      filt_q      <= 2'b00;
      prime_cnt_q <= '0;
      step_q      <= 1'b0;
      count_up_q  <= 1'b0;
      position_q  <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      filt_q      <= filt_d;
      prime_cnt_q <= prime_cnt_d;
      step_q      <= step_d;
      count_up_q  <= count_up_d;
      position_q  <= position_d;
      error_q     <= error_d;
    end
  end

  // Next-state decode. INIT waits until the history holds only post-reset
  // samples, then adopts the first stable value so a static input never steps.
  always_comb begin
    state_d     = state_q;
    filt_d      = filt_q;
    prime_cnt_d = prime_cnt_q;
    step_d      = 1'b0;
    count_up_d  = count_up_q;
    position_d  = position_q;
    error_d     = error_q;

    if (err_clr) error_d = 1'b0;

    case (state_q)
      ST_INIT: begin
        if (!primed_c) begin
          prime_cnt_d = prime_cnt_q + CNT_W'(1);
        end else if (stable_c) begin
          filt_d  = cand_c;
          state_d = ST_TRACK;
        end
      end
      ST_TRACK: begin
        if (stable_c && (cand_c != filt_q)) begin
          filt_d = cand_c;
          case (dir_c)
            2'd1: begin
              if (enable) begin
                step_d     = 1'b1;
                count_up_d = 1'b1;
                position_d = position_q + WIDTH'(1);
              end
            end
            2'd3: begin
              if (enable) begin
                step_d     = 1'b1;
                count_up_d = 1'b0;
                position_d = position_q - WIDTH'(1);
              end
            end
            default: error_d = 1'b1;
          endcase
        end
      end
      default: state_d = ST_INIT;
    endcase

    // Load wins over a same-cycle step update.
    if (load_any_c) position_d = init_value;
  end

  assign step     = step_q;
  assign count_up = count_up_q;
  assign position = position_q;
  assign error    = error_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed testbench for quad_decoder at WIDTH=3, SYNC_STAGES=2, FILTER_LEN=2.
module tb_quad_decoder;

  logic       clk;
  logic       reset_n;
  logic       a_in;
  logic       b_in;
  logic       enable;
  logic       load;
  logic [2:0] init_value;
  logic       err_clr;
  logic       step;
  logic       count_up;
  logic [2:0] position;
  logic       error;

  int checks;
  int errors;

  quad_decoder #(
    .WIDTH      (3),
    .SYNC_STAGES(2),
    .FILTER_LEN (2)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .a_in      (a_in),
    .b_in      (b_in),
    .enable    (enable),
    .load      (load),
    .init_value(init_value),
    .err_clr   (err_clr),
    .step      (step),
    .count_up  (count_up),
    .position  (position),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive a new A/B level, hold 8 cycles, check the acceptance edge (edge 5).
  // clr/ld are asserted only on the cycle sampled by edge 5.
  task automatic drive(input string tag, input logic a, input logic b,
                       input logic exp_step, input logic exp_up,
                       input logic [2:0] exp_pos, input logic exp_err,
                       input logic clr, input logic ld);
    a_in = a;
    b_in = b;
    tick(4);
    check({tag, ".early_step"}, step, 1'b0);
    err_clr = clr;
    load    = ld;
    tick(1);
    err_clr = 1'b0;
    load    = 1'b0;
    check({tag, ".step"}, step, exp_step);
    check({tag, ".count_up"}, count_up, exp_up);
    check({tag, ".position"}, position, exp_pos);
    check({tag, ".error"}, error, exp_err);
    tick(1);
    check({tag, ".step_width"}, step, 1'b0);
    tick(2);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset_n    = 1'b0;
    a_in       = 1'b0;
    b_in       = 1'b0;
    enable     = 1'b1;
    load       = 1'b0;
    init_value = 3'd0;
    err_clr    = 1'b0;

    // Reset state.
    tick(3);
    check("rst.step", step, 1'b0);
    check("rst.count_up", count_up, 1'b0);
    check("rst.position", position, 3'd0);
    check("rst.error", error, 1'b0);
    reset_n = 1'b1;
    tick(8);
    check("prime.step", step, 1'b0);
    check("prime.position", position, 3'd0);

    // Forward sequence 00->01->11->10->00.
    drive("fwd01", 1'b0, 1'b1, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
    drive("fwd11", 1'b1, 1'b1, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
    drive("fwd10", 1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
    drive("fwd00", 1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0);

    // Load 1, then reverse 00->10->11 wraps 0 -> 7.
    init_value = 3'd1;
    load = 1'b1;
    tick(1);
    load = 1'b0;
    check("load1.position", position, 3'd1);
    drive("rev10", 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    drive("rev11", 1'b1, 1'b1, 1'b1, 1'b0, 3'd7, 1'b0, 1'b0, 1'b0);

    // Back to 00 (forward 11->10->00, 7 wraps to 0), then a 1-cycle glitch.
    drive("fwd10b", 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
    drive("fwd00b", 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
    a_in = 1'b1;
    tick(1);
    a_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("glitch.step", step, 1'b0);
      tick(1);
    end
    check("glitch.position", position, 3'd1);
    // 00->01 only steps forward if filt stayed 00.
    drive("glitch.fwd01", 1'b0, 1'b1, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0);

    // Illegal transitions and sticky error.
    drive("rev00", 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0);
    drive("ill11", 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0);
    check("ill11.sticky", error, 1'b1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("errclr.error", error, 1'b0);
    drive("ill00.clr", 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0);
    check("ill00.sticky", error, 1'b1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("errclr2.error", error, 1'b0);

    // Mid-operation reset with a static 11 input.
    drive("fwd01c", 1'b0, 1'b1, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
    a_in = 1'b1;
    b_in = 1'b1;
    reset_n = 1'b0;
    #1;
    check("midrst.position", position, 3'd0);
    check("midrst.count_up", count_up, 1'b0);
    tick(2);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("reprime.step", step, 1'b0);
      check("reprime.error", error, 1'b0);
      tick(1);
    end
    check("reprime.position", position, 3'd0);
    drive("rst.fwd10", 1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);

    // Load coincident with a forward step: load wins on position.
    init_value = 3'd5;
    drive("ldstep", 1'b0, 1'b0, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 1'b1);

    // enable = 0: filt tracks, no step, count_up and position held.
    enable = 1'b0;
    drive("dis.fwd01", 1'b0, 1'b1, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0);
    drive("dis.rev00", 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0);
    enable = 1'b1;
    drive("en.fwd01", 1'b0, 1'b1, 1'b1, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0);

    // 7 + 1 wraps to 0.
    init_value = 3'd7;
    load = 1'b1;
    tick(1);
    load = 1'b0;
    check("load7.position", position, 3'd7);
    drive("wrap.fwd11", 1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
